// File: rtl/fetch_if.sv
// fetch_if: ROM address/data, redirect and decode handshake bundle for fetch_controller.
interface fetch_if #(parameter int DATA_WIDTH = 32);
  logic fetch_enable;
  logic [DATA_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_instruction;
  logic redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic instr_valid;
  logic instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic busy_full;
  logic [DATA_WIDTH-1:0] delivered_count;
  modport master (
    input  fetch_enable, rom_instruction, redirect_valid, redirect_pc, instr_ready,
    output rom_address, instr_valid, instr_data, instr_pc, busy_full, delivered_count
  );
  modport slave (
    output fetch_enable, rom_instruction, redirect_valid, redirect_pc, instr_ready,
    input  rom_address, instr_valid, instr_data, instr_pc, busy_full, delivered_count
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing over an async program ROM with a flushable prefetch queue toward decode.
module fetch_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input logic clk,
  input logic reset,
  fetch_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
  state_t state, state_next;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] delivered;
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_pc [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic valid, push, pop;
  assign valid = count != '0;
  assign bus.rom_address = pc_reg;
  assign bus.instr_valid = valid;
  assign bus.busy_full = count == FULL;
  assign bus.instr_data = valid ? q_data[rd_ptr] : '0;
  assign bus.instr_pc = valid ? q_pc[rd_ptr] : '0;
  assign bus.delivered_count = delivered;
  // A pop frees a slot in the same cycle, so a full queue still streams one word per cycle.
  always_comb begin
    pop = valid && bus.instr_ready;
    push = state != IDLE && bus.fetch_enable && !bus.redirect_valid && (count < FULL || pop);
    count_next = bus.redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    state_next = state == IDLE ? (bus.fetch_enable && !bus.redirect_valid ? FETCH : IDLE)
               : !bus.fetch_enable ? IDLE
               : bus.redirect_valid ? FETCH
               : state == STALL ? (pop ? FETCH : STALL)
               : (count_next == FULL && !pop ? STALL : FETCH);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_reg <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      delivered <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (pop) delivered <= delivered + DATA_WIDTH'(1);
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        pc_reg <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push) begin
          q_data[wr_ptr] <= bus.rom_instruction;
          q_pc[wr_ptr] <= pc_reg;
          wr_ptr <= wr_ptr + AW'(1);
          pc_reg <= pc_reg + DATA_WIDTH'(4);
        end
      end
    end
  end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the combinational program ROM for the processor core. It owns the program counter, drives the ROM address, and captures each returned instruction together with its PC into a small prefetch queue. The queue is presented to decode through a valid/ready handshake. Decode or branch logic can redirect fetch, which flushes every queued instruction.

Parameters:
DATA_WIDTH, 32, width of address, PC and instruction
QUEUE_DEPTH, 2, prefetch queue entries; legal values 2 or 4 (power of two)
RESET_PC, 32'h0040_0000, PC loaded on reset; must be word aligned

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous reset, active-high
fetch_enable  input  1  1 = fetching allowed; 0 = PC frozen, queue keeps draining
rom_address  output  DATA_WIDTH  byte address to program memory; equals pc_reg
rom_instruction  input  DATA_WIDTH  combinational ROM read data for rom_address
redirect_valid  input  1  flush the queue and load a new PC this cycle
redirect_pc  input  DATA_WIDTH  target byte address; bits [1:0] ignored
instr_valid  output  1  queue head is valid
instr_ready  input  1  decode accepts the head this cycle
instr_data  output  DATA_WIDTH  head instruction
instr_pc  output  DATA_WIDTH  byte address of the head instruction
busy_full  output  1  queue count == QUEUE_DEPTH
delivered_count  output  DATA_WIDTH  number of completed instr handshakes; wraps modulo 2^DATA_WIDTH

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pc_reg=RESET_PC; queue count=0; read/write pointers=0; delivered_count=0; state=IDLE.
  - Consequently instr_valid=0, busy_full=0, rom_address=RESET_PC.
  - instr_data and instr_pc read 0 while the queue is empty.
  - Reset overrides every other input, including a redirect in the same cycle.
- rom_address is driven from pc_reg combinationally. The ROM is asynchronous, so rom_instruction is valid in the same cycle; capture latency is 0 cycles.
- State machine:
  - IDLE: no fetch. Go to FETCH when fetch_enable=1.
  - FETCH: push enabled. Go to STALL when the queue becomes full with no pop. Go to IDLE when fetch_enable=0.
  - STALL: queue full, PC held. Go to FETCH on a pop or a redirect. Go to IDLE when fetch_enable=0 (the queue is retained).
- push condition: state!=IDLE, fetch_enable=1, redirect_valid=0, and either count<QUEUE_DEPTH or a pop occurs this cycle.
  - On push: write {pc_reg, rom_instruction} at the write pointer, then pc_reg += 4 (wraps at 2^DATA_WIDTH).
- pop condition: instr_valid && instr_ready.
  - On pop: advance the read pointer and increment delivered_count.
  - A handshake during a redirect cycle still counts as delivered.
- Simultaneous push and pop: count is unchanged and both pointers advance. When the queue is full, this gives one instruction per cycle.
- Redirect (redirect_valid=1, no reset):
  - count=0 and pointers=0.
  - pc_reg={redirect_pc[DATA_WIDTH-1:2],2'b00}.
  - No push that cycle. From IDLE the state stays IDLE; otherwise it goes to FETCH.
  - instr_valid is 0 on the next cycle. The first post-redirect instruction is valid 1 cycle after the redirect edge.
- fetch_enable=0: no pushes and pc_reg holds. Pops and redirects still operate.
- instr_valid=(count!=0). Head outputs are stable while instr_valid=1 and instr_ready=0 (no redirect).
- pc_reg bits [1:0] are always 0.

Test Plan:
1. Reset, fetch_enable=1, instr_ready=1; ROM word at 0x00400000=0x20080005, at 0x00400004=0x20090003 -> first handshake gives instr_pc=0x00400000, data=0x20080005; the next cycle gives 0x00400004, data=0x20090003; delivered_count=2.
2. instr_ready=0 for 5 cycles after reset -> after 2 pushes busy_full=1, rom_address holds 0x00400008, head stays 0x00400000. Then instr_ready=1 -> one handshake per cycle, PCs 0x...00, 04, 08 in order.
3. With the queue full, pulse redirect_valid with redirect_pc=0x0040002E -> next cycle instr_valid=0, rom_address=0x0040002C; one cycle later instr_pc=0x0040002C; older entries are never delivered.
4. Drop fetch_enable with 2 entries queued, instr_ready=1 -> both entries are delivered, then instr_valid=0 and rom_address is frozen. Raise fetch_enable -> fetch resumes at the frozen PC.
5. Assert reset mid-stream with redirect_valid=1 in the same cycle -> after the edge count=0, delivered_count=0, rom_address=0x00400000.
6. Redirect to 0xFFFFFFFC with fetch running -> next pushes have PCs 0xFFFFFFFC then 0x00000000 (PC wrap).
